fft_spi_streamer: RTL and testbench

Parametrised successor of the FFT SPI output stage. Snapshots a full bank of complex FFT bins, then serialises them over an integrated SPI mode-0 transmitter: optional header byte, then real/imag of each bin, multi-byte words MSB-byte first. Adds configurable word width, SCLK rate, inter-byte gap and chip-select framing, plus done, busy and overrun status. Sits between the FFT result register bank and the board SPI pins.

---
 rtl/fft_spi_streamer.sv | 137 +++++++++++++
 tb/tb_fft_spi_streamer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spi_streamer.sv
// Snapshots a bank of complex FFT bins and streams them out over SPI mode 0:
// optional sync header byte, then real/imag of every bin, MSB byte and MSB bit first.
module fft_spi_streamer #(
    parameter int         N_BINS            = 32,
    parameter int         DATA_W            = 8,
    parameter int         CLKS_PER_HALF_BIT = 2,
    parameter int         GAP_CLKS          = 64,
    parameter int         HEADER_EN         = 1,
    parameter logic [7:0] HEADER_BYTE       = 8'hA5,
    parameter int         CS_PER_BYTE       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*N_BINS*DATA_W-1:0]   data_bus,
    input  logic                         start,
    output logic                         sclk,
    output logic                         mosi,
    output logic                         cs_n,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int B      = DATA_W / 8;
    localparam int NBYTES = 2 * N_BINS * B;
    localparam int T      = HEADER_EN + NBYTES;
    localparam int CNT_W  = $clog2(T + 1);
    localparam int HALF_W = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam int GAP_W  = $clog2(GAP_CLKS + 1);

    localparam logic [HALF_W-1:0] HALF_MID = HALF_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [HALF_W-1:0] HALF_END = HALF_W'(2 * CLKS_PER_HALF_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_CLKS - 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(T - 1);
    localparam logic [CNT_W-1:0]  T_CNT    = CNT_W'(T);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t                    state;
    logic [2*N_BINS*DATA_W-1:0] snap;
    logic [7:0]                shreg;
    logic [7:0]                next_byte;
    logic [CNT_W-1:0]          byte_cnt;
    logic [2:0]                bit_cnt;
    logic [HALF_W-1:0]         half_cnt;
    logic [GAP_W-1:0]          gap_cnt;

    // Stream byte k maps to element k/B, taking that element's bytes MSB first.
    always_comb begin
        next_byte = HEADER_BYTE;
        for (int k = 0; k < NBYTES; k++) begin
            if (int'(byte_cnt) == k + HEADER_EN)
                next_byte = snap[((k / B) * B + (B - 1 - (k % B))) * 8 +: 8];
        end
    end

    // Datapath registers: frame snapshot and the byte being shifted out.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start)
            snap <= data_bus;
        if (state == S_LOAD)
            shreg <= next_byte;
        else if (state == S_SHIFT && half_cnt == HALF_END)
            shreg <= {shreg[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (start && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    mosi     <= next_byte[7];
                    cs_n     <= 1'b0;
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (half_cnt == HALF_MID)
                        sclk <= 1'b1;
                    if (half_cnt == HALF_END) begin
                        half_cnt <= '0;
                        sclk     <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            // mosi keeps the last bit through the gap.
                            gap_cnt  <= '0;
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= S_GAP;
                            if (CS_PER_BYTE != 0 || byte_cnt == LAST_IDX)
                                cs_n <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            mosi    <= shreg[6];
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_END)
                        state <= (byte_cnt == T_CNT) ? S_DONE : S_LOAD;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cs_n  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_spi_streamer.sv
// Bench for fft_spi_streamer: three configurations driven with random and directed
// frames; an SPI decoder and a byte-list model check content, framing and timing.
module tb_fft_spi_streamer;

    localparam int NI = 3;
    localparam int         NB_C   [NI] = '{2, 1, 3};
    localparam int         DW_C   [NI] = '{16, 8, 24};
    localparam int         HALF_C [NI] = '{2, 2, 1};
    localparam int         GAP_C  [NI] = '{4, 4, 3};
    localparam int         HDR_C  [NI] = '{1, 0, 1};
    localparam logic [7:0] HB_C   [NI] = '{8'hA5, 8'hA5, 8'h3C};
    localparam int         CSB_C  [NI] = '{0, 1, 1};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NI-1:0]  start_v = '0;
    logic [255:0]   data_all = '0;
    wire  [NI-1:0]  sclk_v, mosi_v, cs_v, busy_v, done_v, ovr_v;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [NI-1:0] ovr_exp = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_spi_streamer #(.N_BINS(NB_C[0]), .DATA_W(DW_C[0]), .CLKS_PER_HALF_BIT(HALF_C[0]),
        .GAP_CLKS(GAP_C[0]), .HEADER_EN(HDR_C[0]), .HEADER_BYTE(HB_C[0]), .CS_PER_BYTE(CSB_C[0]))
    dut_a (.clk(clk), .rst(rst), .data_bus(data_all[2*NB_C[0]*DW_C[0]-1:0]), .start(start_v[0]),
        .sclk(sclk_v[0]), .mosi(mosi_v[0]), .cs_n(cs_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .overrun(ovr_v[0]));

    fft_spi_streamer #(.N_BINS(NB_C[1]), .DATA_W(DW_C[1]), .CLKS_PER_HALF_BIT(HALF_C[1]),
        .GAP_CLKS(GAP_C[1]), .HEADER_EN(HDR_C[1]), .HEADER_BYTE(HB_C[1]), .CS_PER_BYTE(CSB_C[1]))
    dut_b (.clk(clk), .rst(rst), .data_bus(data_all[2*NB_C[1]*DW_C[1]-1:0]), .start(start_v[1]),
        .sclk(sclk_v[1]), .mosi(mosi_v[1]), .cs_n(cs_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .overrun(ovr_v[1]));

    fft_spi_streamer #(.N_BINS(NB_C[2]), .DATA_W(DW_C[2]), .CLKS_PER_HALF_BIT(HALF_C[2]),
        .GAP_CLKS(GAP_C[2]), .HEADER_EN(HDR_C[2]), .HEADER_BYTE(HB_C[2]), .CS_PER_BYTE(CSB_C[2]))
    dut_c (.clk(clk), .rst(rst), .data_bus(data_all[2*NB_C[2]*DW_C[2]-1:0]), .start(start_v[2]),
        .sclk(sclk_v[2]), .mosi(mosi_v[2]), .cs_n(cs_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .overrun(ovr_v[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SPI receiver model: samples mosi on sclk rising edges, tracks cs_n windows and phases.
    logic [NI-1:0] prev_sclk = '0;
    logic [NI-1:0] prev_cs   = '1;
    logic [NI-1:0] prev_mosi = '0;
    logic [7:0]    acc       [NI];
    logic [7:0]    rx_buf    [NI][512];
    int            nbits     [NI];
    int            rx_n      [NI];
    int            win_cnt   [NI];
    int            done_cnt  [NI];
    int            hi_run    [NI];
    int            lo_run    [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            acc[i] = '0; nbits[i] = 0; rx_n[i] = 0; win_cnt[i] = 0;
            done_cnt[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                nbits[i] = 0;
            end else begin
                if (prev_cs[i] && !cs_v[i]) win_cnt[i]++;
                if (done_v[i]) done_cnt[i]++;
                if (!prev_sclk[i] && sclk_v[i]) begin
                    chk("mosi_at_rise", 32'(mosi_v[i]), 32'(prev_mosi[i]));
                    chk("cs_low_at_rise", 32'(cs_v[i]), 0);
                    if (nbits[i] != 0) chk("sclk_low_len", lo_run[i], HALF_C[i]);
                    acc[i] = {acc[i][6:0], mosi_v[i]};
                    nbits[i]++;
                    if (nbits[i] == 8) begin
                        rx_buf[i][rx_n[i] % 512] = acc[i];
                        rx_n[i]++;
                        nbits[i] = 0;
                    end
                    hi_run[i] = 1;
                end else if (prev_sclk[i] && !sclk_v[i]) begin
                    chk("sclk_high_len", hi_run[i], HALF_C[i]);
                    lo_run[i] = 1;
                end else if (sclk_v[i]) begin
                    chk("mosi_stable_high", 32'(mosi_v[i]), 32'(prev_mosi[i]));
                    hi_run[i]++;
                end else begin
                    lo_run[i]++;
                end
            end
            prev_sclk[i] = sclk_v[i];
            prev_cs[i]   = cs_v[i];
            prev_mosi[i] = mosi_v[i];
        end
    end

    function automatic int frame_bytes(input int i);
        return HDR_C[i] + 2 * NB_C[i] * (DW_C[i] / 8);
    endfunction

    function automatic int frame_cycles(input int i);
        return frame_bytes(i) * (1 + 16 * HALF_C[i] + GAP_C[i]) + 1;
    endfunction

    // One full frame on instance i; optionally scribble data_bus after capture and
    // issue a second start in mid-frame.
    task automatic run_frame(input int i, input logic [255:0] d, input bit corrupt, input bit restart);
        logic [7:0] exp_q[$];
        int t_bytes, d_cyc, rx0, win0, done0, s, n, busy_bad;
        bit got_done;
        t_bytes = frame_bytes(i);
        d_cyc   = frame_cycles(i);
        if (HDR_C[i] != 0) exp_q.push_back(HB_C[i]);
        for (int e = 0; e < 2 * NB_C[i]; e++)
            for (int j = DW_C[i] / 8 - 1; j >= 0; j--)
                exp_q.push_back(d[e * DW_C[i] + j * 8 +: 8]);
        rx0 = rx_n[i]; win0 = win_cnt[i]; done0 = done_cnt[i];
        data_all   = d;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        s = cyc;
        if (corrupt) data_all = '1;
        n = 0; got_done = 1'b0; busy_bad = 0;
        while (!got_done && n < d_cyc + 20) begin
            start_v[i] = (restart && n == 50);
            @(negedge clk);
            n++;
            if (done_v[i]) got_done = 1'b1;
            else if (!busy_v[i]) busy_bad++;
        end
        start_v[i] = 1'b0;
        if (restart) ovr_exp[i] = 1'b1;
        chk("done_seen", 32'(got_done), 1);
        chk("start_to_done", cyc - s, d_cyc);
        chk("busy_in_frame", busy_bad, 0);
        chk("busy_after_done", 32'(busy_v[i]), 0);
        chk("overrun", 32'(ovr_v[i]), 32'(ovr_exp[i]));
        @(negedge clk);
        chk("done_one_cycle", 32'(done_v[i]), 0);
        chk("done_count", done_cnt[i] - done0, 1);
        chk("cs_idle", 32'(cs_v[i]), 1);
        chk("sclk_idle", 32'(sclk_v[i]), 0);
        chk("byte_count", rx_n[i] - rx0, t_bytes);
        for (int k = 0; k < t_bytes; k++)
            chk($sformatf("byte%0d_inst%0d", k, i), 32'(rx_buf[i][(rx0 + k) % 512]), 32'(exp_q[k]));
        chk("cs_windows", win_cnt[i] - win0, (CSB_C[i] != 0) ? t_bytes : 1);
    endtask

    function automatic logic [255:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, done0;
        logic [255:0] d;
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_sclk", 32'(sclk_v[i]), 0);
            chk("rst_mosi", 32'(mosi_v[i]), 0);
            chk("rst_cs_n", 32'(cs_v[i]), 1);
            chk("rst_busy", 32'(busy_v[i]), 0);
            chk("rst_done", 32'(done_v[i]), 0);
            chk("rst_overrun", 32'(ovr_v[i]), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames: 16-bit elements with header, then 8-bit headerless pair.
        d = '0;
        d[63:0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        run_frame(0, d, 1'b0, 1'b0);
        d = '0;
        d[15:0] = {8'hC3, 8'h5A};
        run_frame(1, d, 1'b0, 1'b0);
        run_frame(2, rand_data(), 1'b0, 1'b0);

        // Snapshot isolation and overrun.
        run_frame(0, rand_data(), 1'b1, 1'b1);
        run_frame(0, rand_data(), 1'b0, 1'b0);

        // Reset during bit 3 of byte 2 aborts the frame.
        d = rand_data();
        done0 = done_cnt[0];
        data_all   = d;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        s = cyc;
        while (cyc - s < 88) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", 32'(cs_v[0]), 1);
        chk("abort_sclk", 32'(sclk_v[0]), 0);
        chk("abort_busy", 32'(busy_v[0]), 0);
        chk("abort_done", 32'(done_v[0]), 0);
        chk("abort_overrun", 32'(ovr_v[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        ovr_exp = '0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt[0] - done0, 0);
        run_frame(0, rand_data(), 1'b0, 1'b0);

        // start coinciding with rst is dropped.
        rst = 1'b1;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("start_with_rst_busy", 32'(busy_v[1]), 0);
        chk("start_with_rst_cs", 32'(cs_v[1]), 1);

        // Randomized frames across all configurations.
        for (int r = 0; r < 8; r++)
            run_frame($urandom_range(0, NI - 1), rand_data(),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
